// File: rtl/pipe_hold_sched_if.sv
// Handshake bundle between the pipeline sequencer and the pc_reg/if_id/id_ex/EX/CLINT side.
// The slave modport is the sequencer's view; master is the surrounding pipeline's view.
interface pipe_hold_sched_if #(
  parameter int CNT_W = 32
);
  logic             jump_flag_i;
  logic [31:0]      jump_addr_i;
  logic             int_assert_i;
  logic [31:0]      int_addr_i;
  logic             int_ack_o;
  logic             div_busy_i;
  logic             rib_hold_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_rd_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_rs1_re_i;
  logic             id_rs2_re_i;
  logic [2:0]       hold_flag_o;
  logic             jump_flag_o;
  logic [31:0]      jump_addr_o;
  logic             div_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  jump_flag_i, jump_addr_i, int_assert_i, int_addr_i, div_busy_i, rib_hold_i,
           ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
    output int_ack_o, hold_flag_o, jump_flag_o, jump_addr_o, div_timeout_o, stall_cnt_o
  );

  modport master (
    output jump_flag_i, jump_addr_i, int_assert_i, int_addr_i, div_busy_i, rib_hold_i,
           ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
    input  int_ack_o, hold_flag_o, jump_flag_o, jump_addr_o, div_timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_hold_sched.sv
// Pipeline sequencer: arbitrates redirects and stall sources into the shared hold_flag bus,
// with a flush window after every redirect and a sticky divider-timeout flag.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | normal flow; full priority arbitration each cycle
// S_FLUSH  | Hold_Id after a redirect until fcnt expires; redirects restart it
// S_DIV    | divider busy; Hold_Id, interrupts stay pending until busy drops
module pipe_hold_sched #(
  parameter int FLUSH_CYCLES = 2,
  parameter int DIV_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hold_sched_if.slave bus
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int DW = $clog2(DIV_TIMEOUT + 1);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             div_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             load_use;
  logic             eval_idle;
  logic [2:0]       hold;
  logic             redir;
  logic [31:0]      redir_addr;
  logic             ack;

  assign load_use = bus.ex_is_load_i && (bus.ex_rd_i != 5'd0) &&
                    ((bus.id_rs1_re_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
                     (bus.id_rs2_re_i && (bus.id_rs2_i == bus.ex_rd_i)));

  // A divider wait that ends is arbitrated exactly like IDLE in the same cycle.
  assign eval_idle = (state_q == S_IDLE) || ((state_q == S_DIV) && !bus.div_busy_i);

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    dcnt_d     = dcnt_q;
    hold       = HOLD_NONE;
    redir      = 1'b0;
    redir_addr = 32'd0;
    ack        = 1'b0;

    if (state_q == S_FLUSH) begin
      hold = HOLD_ID;
      if (bus.int_assert_i) begin
        redir      = 1'b1;
        redir_addr = bus.int_addr_i;
        ack        = 1'b1;
      end else if (bus.jump_flag_i) begin
        redir      = 1'b1;
        redir_addr = bus.jump_addr_i;
      end
      if (redir) begin
        fcnt_d  = FW'(FLUSH_CYCLES - 1);
        state_d = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
      end else begin
        fcnt_d = fcnt_q - FW'(1);
        if (fcnt_q == FW'(1)) state_d = S_IDLE;
      end
    end else if (state_q == S_DIV && bus.div_busy_i) begin
      hold = HOLD_ID;
      if (dcnt_q != DW'(DIV_TIMEOUT)) dcnt_d = dcnt_q + DW'(1);
    end

    if (eval_idle) begin
      state_d = S_IDLE;
      dcnt_d  = '0;
      if (bus.int_assert_i || bus.jump_flag_i) begin
        hold       = HOLD_ID;
        redir      = 1'b1;
        ack        = bus.int_assert_i;
        redir_addr = bus.int_assert_i ? bus.int_addr_i : bus.jump_addr_i;
        fcnt_d     = FW'(FLUSH_CYCLES - 1);
        state_d    = (FLUSH_CYCLES > 1) ? S_FLUSH : S_IDLE;
      end else if (bus.div_busy_i) begin
        hold    = HOLD_ID;
        dcnt_d  = DW'(1);
        state_d = S_DIV;
      end else if (load_use) begin
        hold = HOLD_ID;
      end else if (bus.rib_hold_i) begin
        hold = HOLD_PC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      fcnt_q        <= '0;
      dcnt_q        <= '0;
      div_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
      if (dcnt_d == DW'(DIV_TIMEOUT)) div_timeout_q <= 1'b1;
      if (hold != HOLD_NONE && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Combinational outputs are squelched while reset is held, whatever the inputs do.
  assign bus.hold_flag_o   = rst ? hold : HOLD_NONE;
  assign bus.jump_flag_o   = rst & redir;
  assign bus.jump_addr_o   = rst ? redir_addr : 32'd0;
  assign bus.int_ack_o     = rst & ack;
  assign bus.div_timeout_o = div_timeout_q;
  assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hold_sched.sv
// Directed and randomized bench for pipe_hold_sched against a cycle-level behavioural model.
module tb_pipe_hold_sched;

  localparam int FC    = 2;
  localparam int DT    = 64;
  localparam int CNT_W = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Model state: owed flush cycles, divider stall streak, sticky timeout, stall count.
  int     flush_owed;
  bit     div_wait;
  int     div_streak;
  bit     m_timeout;
  longint m_stalls;

  pipe_hold_sched_if #(.CNT_W(CNT_W)) bus ();

  pipe_hold_sched #(
    .FLUSH_CYCLES(FC),
    .DIV_TIMEOUT (DT),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    flush_owed = 0;
    div_wait   = 0;
    div_streak = 0;
    m_timeout  = 0;
    m_stalls   = 0;
  endtask

  task automatic clear_inputs();
    bus.jump_flag_i  = 0; bus.jump_addr_i = 0;
    bus.int_assert_i = 0; bus.int_addr_i  = 0;
    bus.div_busy_i   = 0; bus.rib_hold_i  = 0;
    bus.ex_is_load_i = 0; bus.ex_rd_i     = 0;
    bus.id_rs1_i     = 0; bus.id_rs2_i    = 0;
    bus.id_rs1_re_i  = 0; bus.id_rs2_re_i = 0;
  endtask

  // One clock cycle: inputs already driven; evaluate at negedge, advance at posedge.
  task automatic step(input string tag);
    logic [2:0]  e_hold;
    bit          e_jf, e_ack, lu;
    logic [31:0] e_addr;
    @(negedge clk);
    chk({tag, ".stall_cnt"}, 64'(bus.stall_cnt_o), 64'(m_stalls));
    chk({tag, ".div_timeout"}, 64'(bus.div_timeout_o), 64'(m_timeout));
    lu = bus.ex_is_load_i && bus.ex_rd_i != 0 &&
         ((bus.id_rs1_re_i && bus.id_rs1_i == bus.ex_rd_i) ||
          (bus.id_rs2_re_i && bus.id_rs2_i == bus.ex_rd_i));
    e_hold = 0; e_jf = 0; e_ack = 0; e_addr = 0;
    if (flush_owed > 0) begin
      e_hold = 3;
      if (bus.int_assert_i) begin
        e_jf = 1; e_ack = 1; e_addr = bus.int_addr_i;
      end else if (bus.jump_flag_i) begin
        e_jf = 1; e_addr = bus.jump_addr_i;
      end
      flush_owed = e_jf ? FC - 1 : flush_owed - 1;
    end else if (div_wait && bus.div_busy_i) begin
      e_hold = 3;
      div_streak = (div_streak + 1 > DT) ? DT : div_streak + 1;
    end else begin
      div_wait = 0;
      div_streak = 0;
      if (bus.int_assert_i || bus.jump_flag_i) begin
        e_hold = 3; e_jf = 1; e_ack = bus.int_assert_i;
        e_addr = bus.int_assert_i ? bus.int_addr_i : bus.jump_addr_i;
        flush_owed = FC - 1;
      end else if (bus.div_busy_i) begin
        e_hold = 3; div_wait = 1; div_streak = 1;
      end else if (lu) begin
        e_hold = 3;
      end else if (bus.rib_hold_i) begin
        e_hold = 1;
      end
    end
    if (div_streak >= DT) m_timeout = 1;
    if (e_hold != 0 && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    chk({tag, ".hold"}, 64'(bus.hold_flag_o), 64'(e_hold));
    chk({tag, ".jump_flag"}, 64'(bus.jump_flag_o), 64'(e_jf));
    chk({tag, ".jump_addr"}, 64'(bus.jump_addr_o), 64'(e_addr));
    chk({tag, ".int_ack"}, 64'(bus.int_ack_o), 64'(e_ack));
    @(posedge clk);
    #1;
    if (e_ack) bus.int_assert_i = 0;
  endtask

  initial begin
    int busy_left;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    clear_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    bus.jump_flag_i = 1; bus.jump_addr_i = 32'hDEAD_0000;
    #1;
    chk("reset.hold", 64'(bus.hold_flag_o), 64'd0);
    chk("reset.jump_flag", 64'(bus.jump_flag_o), 64'd0);
    chk("reset.jump_addr", 64'(bus.jump_addr_o), 64'd0);
    chk("reset.stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
    clear_inputs();
    rst = 1;

    for (int i = 0; i < 10; i++) step("idle");

    bus.jump_flag_i = 1; bus.jump_addr_i = 32'h100;
    step("jump");
    clear_inputs();
    repeat (3) step("jump_flush");
    chk("jump.total_stalls", 64'(bus.stall_cnt_o), 64'd2);

    bus.ex_is_load_i = 1; bus.ex_rd_i = 5; bus.id_rs2_i = 5; bus.id_rs2_re_i = 1;
    step("load_use");
    bus.ex_rd_i = 0; bus.id_rs2_i = 0;
    step("load_rd0");
    clear_inputs();
    step("load_after");

    bus.int_addr_i = 32'h8000_0040;
    bus.div_busy_i = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 10) bus.int_assert_i = 1;
      step("div_busy");
    end
    chk("div.timeout_sticky", 64'(bus.div_timeout_o), 64'd1);
    bus.div_busy_i = 0;
    step("div_drop");
    clear_inputs();
    repeat (3) step("div_after");

    bus.int_assert_i = 1; bus.int_addr_i = 32'h0000_0200;
    bus.jump_flag_i  = 1; bus.jump_addr_i = 32'h0000_0300;
    step("int_vs_jump");
    bus.jump_flag_i = 0;
    step("flush_a");
    bus.jump_flag_i = 1; bus.jump_addr_i = 32'h0000_0400;
    step("flush_restart");
    bus.jump_flag_i = 0;
    repeat (3) step("flush_tail");

    bus.rib_hold_i = 1;
    bus.ex_is_load_i = 1; bus.ex_rd_i = 7; bus.id_rs1_i = 7; bus.id_rs1_re_i = 1;
    step("rib_load_use");
    bus.ex_is_load_i = 0;
    step("rib_only");
    clear_inputs();

    bus.jump_flag_i = 1; bus.jump_addr_i = 32'h0000_0500;
    step("pre_reset_jump");
    #2;
    rst = 0;
    #1;
    chk("rst_flush.hold", 64'(bus.hold_flag_o), 64'd0);
    chk("rst_flush.jump_flag", 64'(bus.jump_flag_o), 64'd0);
    chk("rst_flush.jump_addr", 64'(bus.jump_addr_o), 64'd0);
    chk("rst_flush.int_ack", 64'(bus.int_ack_o), 64'd0);
    chk("rst_flush.stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
    chk("rst_flush.div_timeout", 64'(bus.div_timeout_o), 64'd0);
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1;
    repeat (3) step("post_reset");

    busy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.jump_flag_i = ($urandom_range(0, 15) == 0);
      bus.jump_addr_i = $urandom;
      if (!bus.int_assert_i && $urandom_range(0, 29) == 0) begin
        bus.int_assert_i = 1;
        bus.int_addr_i   = $urandom;
      end
      if (busy_left > 0) busy_left--;
      else if ($urandom_range(0, 19) == 0)
        busy_left = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 8);
      bus.div_busy_i   = (busy_left > 0);
      bus.rib_hold_i   = ($urandom_range(0, 3) == 0);
      bus.ex_is_load_i = $urandom_range(0, 1);
      bus.ex_rd_i      = 5'($urandom_range(0, 3));
      bus.id_rs1_i     = 5'($urandom_range(0, 3));
      bus.id_rs2_i     = 5'($urandom_range(0, 3));
      bus.id_rs1_re_i  = $urandom_range(0, 1);
      bus.id_rs2_re_i  = $urandom_range(0, 1);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
